// File: rtl/fifo_sync_param_if.sv
// Handshake/bus bundle for fifo_sync_param.
// Signal semantics:
//   wr/rd are single-cycle requests sampled on the rising edge. There is no
//   ready signal: a write is accepted when wr=1 and the FIFO is not full, or
//   when it is full and rd=1 in the same cycle. A read is accepted when rd=1
//   and the FIFO is not empty. Rejected requests produce a one-cycle
//   overflow/underflow pulse after that edge. clr is a synchronous flush and
//   overrides wr/rd. All outputs are registered or decoded from registers.
interface fifo_sync_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic                     clr;
    logic                     wr;
    logic [WIDTH-1:0]         datain;
    logic                     rd;
    logic [WIDTH-1:0]         dataout;
    logic                     emp;
    logic                     full;
    logic                     almost_empty;
    logic                     almost_full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    // Host / stream side: drives requests, observes status.
    modport master (
        output clr, wr, datain, rd,
        input  dataout, emp, full, almost_empty, almost_full, count,
               overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  clr, wr, datain, rd,
        output dataout, emp, full, almost_empty, almost_full, count,
               overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with registered read data, occupancy count,
// programmable almost-full/almost-empty flags, overflow/underflow pulses and
// a synchronous flush. WIDTH/DEPTH must match the connected interface.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    fifo_sync_param_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dataout;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_emp;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_mem_we;

    // Status decoded purely from the registered count.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_emp  = (r_count == '0);

    // A full FIFO still takes a write when a read frees the slot in the same edge.
    assign w_wr_acc = bus.wr && (!w_full || bus.rd);
    assign w_rd_acc = bus.rd && !w_emp;
    assign w_mem_we = !bus.clr && w_wr_acc;

    // Storage array: no reset, contents are don't-care after flush/reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= bus.datain;
        end
    end

    // Pointers, count, registered read data and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_dataout   <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_dataout   <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= bus.wr && !w_wr_acc;
            r_underflow <= bus.rd && !w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                // Reads the pre-edge slot, so a same-edge write when full is safe.
                r_dataout <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.dataout      = r_dataout;
    assign bus.count        = r_count;
    assign bus.emp          = w_emp;
    assign bus.full         = w_full;
    assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));
    assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed testbench for fifo_sync_param (WIDTH=8, DEPTH=16, AF=14, AE=2).
module tb_fifo_sync_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_sync_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(DEPTH - 2), .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_ov;
  logic             exp_un;
  int               n_checks;
  int               n_fail;
  int               max_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int c;
    c = exp_q.size();
    check({tag, "_dout"}, 32'(bus.dataout), 32'(exp_dout));
    check({tag, "_count"}, 32'(bus.count), 32'(c));
    check({tag, "_emp"}, 32'(bus.emp), 32'(c == 0));
    check({tag, "_full"}, 32'(bus.full), 32'(c == DEPTH));
    check({tag, "_ae"}, 32'(bus.almost_empty), 32'(c <= 2));
    check({tag, "_af"}, 32'(bus.almost_full), 32'(c >= DEPTH - 2));
    check({tag, "_ov"}, 32'(bus.overflow), 32'(exp_ov));
    check({tag, "_un"}, 32'(bus.underflow), 32'(exp_un));
    if (32'(bus.count) > max_count) max_count = int'(bus.count);
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; drives one cycle, predicts, then checks
  // #1 after the next rising edge.
  task automatic op(input string tag, input logic wr, input logic [WIDTH-1:0] din,
                    input logic rd, input logic clr);
    logic m_full, m_emp, wacc, racc;
    bus.wr     = wr;
    bus.datain = din;
    bus.rd     = rd;
    bus.clr    = clr;
    m_full = (exp_q.size() == DEPTH);
    m_emp  = (exp_q.size() == 0);
    if (clr) begin
      exp_q.delete();
      exp_dout = '0;
      exp_ov   = 1'b0;
      exp_un   = 1'b0;
    end else begin
      wacc   = wr && (!m_full || rd);
      racc   = rd && !m_emp;
      exp_ov = wr && !wacc;
      exp_un = rd && !racc;
      if (racc) exp_dout = exp_q.pop_front();
      if (wacc) exp_q.push_back(din);
    end
    @(posedge clk);
    #1;
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    bus.clr = 1'b0;
    check_status(tag);
  endtask

  task automatic idle(input string tag);
    op(tag, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    max_count = 0;
    exp_dout  = '0;
    exp_ov    = 1'b0;
    exp_un    = 1'b0;
    bus.wr     = 1'b0;
    bus.rd     = 1'b0;
    bus.clr    = 1'b0;
    bus.datain = '0;

    // Reset state
    #1;
    check_status("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic write 3 / read 3
    op("t1_w44", 1'b1, 8'h44, 1'b0, 1'b0);
    check("t1_c1", 32'(bus.count), 32'd1);
    op("t1_w55", 1'b1, 8'h55, 1'b0, 1'b0);
    op("t1_w22", 1'b1, 8'h22, 1'b0, 1'b0);
    check("t1_c3", 32'(bus.count), 32'd3);
    op("t1_r0", 1'b0, '0, 1'b1, 1'b0);
    check("t1_d44", 32'(bus.dataout), 32'h44);
    op("t1_r1", 1'b0, '0, 1'b1, 1'b0);
    check("t1_d55", 32'(bus.dataout), 32'h55);
    op("t1_r2", 1'b0, '0, 1'b1, 1'b0);
    check("t1_d22", 32'(bus.dataout), 32'h22);
    check("t1_emp", 32'(bus.emp), 32'd1);

    // Fill to full, rejected write, drain
    for (int i = 0; i < DEPTH; i++) op("t2_fill", 1'b1, 8'(i), 1'b0, 1'b0);
    check("t2_full", 32'(bus.full), 32'd1);
    op("t2_wAA", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("t2_ovf", 32'(bus.overflow), 32'd1);
    check("t2_c16", 32'(bus.count), 32'd16);
    idle("t2_idle");
    check("t2_ovf_clr", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) op("t2_drain", 1'b0, '0, 1'b1, 1'b0);
    check("t2_last", 32'(bus.dataout), 32'h0F);
    op("t2_rd_emp", 1'b0, '0, 1'b1, 1'b0);
    check("t2_noAA", 32'(bus.dataout), 32'h0F);

    // Simultaneous write/read at full
    for (int i = 0; i < DEPTH; i++) op("t3_fill", 1'b1, 8'(i), 1'b0, 1'b0);
    op("t3_wr_rd", 1'b1, 8'hBB, 1'b1, 1'b0);
    check("t3_d00", 32'(bus.dataout), 32'h00);
    check("t3_c16", 32'(bus.count), 32'd16);
    check("t3_noovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) op("t3_drain", 1'b0, '0, 1'b1, 1'b0);
    check("t3_dBB", 32'(bus.dataout), 32'hBB);

    // Simultaneous write/read when empty
    op("t4_wr_rd", 1'b1, 8'h77, 1'b1, 1'b0);
    check("t4_unf", 32'(bus.underflow), 32'd1);
    check("t4_c1", 32'(bus.count), 32'd1);
    check("t4_dhold", 32'(bus.dataout), 32'hBB);
    op("t4_rd", 1'b0, '0, 1'b1, 1'b0);
    check("t4_d77", 32'(bus.dataout), 32'h77);

    // 40 writes with lagging reads, pointers wrap twice
    for (int i = 0; i < 40; i++) op("t5_stream", 1'b1, 8'(i), (i >= 8), 1'b0);
    for (int i = 0; i < 8; i++) op("t5_drain", 1'b0, '0, 1'b1, 1'b0);
    check("t5_d27", 32'(bus.dataout), 32'h27);
    check("t5_max", 32'(max_count <= DEPTH), 32'd1);

    // Flush with concurrent write
    for (int i = 0; i < 5; i++) op("t6_load", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    op("t6_rd", 1'b0, '0, 1'b1, 1'b0);
    op("t6_clr", 1'b1, 8'h99, 1'b0, 1'b1);
    check("t6_c0", 32'(bus.count), 32'd0);
    check("t6_emp", 32'(bus.emp), 32'd1);
    check("t6_d0", 32'(bus.dataout), 32'd0);
    idle("t6_idle");

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) op("t7_load", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    op("t7_rd", 1'b0, '0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_dout = '0;
    exp_ov   = 1'b0;
    exp_un   = 1'b0;
    check_status("t7_async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    op("t7_w5A", 1'b1, 8'h5A, 1'b0, 1'b0);
    op("t7_r5A", 1'b0, '0, 1'b1, 1'b0);
    check("t7_d5A", 32'(bus.dataout), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO that buffers UART byte streams between the receive/transmit shift logic and the host-side register interface. It generalises the team's fixed 8-bit FIFO with configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, overflow/underflow pulses and a synchronous flush. All state lives in one clock domain. Read data is registered.

## Interface
- WIDTH, 8: data width in bits, at least 1.
- DEPTH, 16: number of entries. Must be a power of 2 and at least 4.
- AF_LEVEL, DEPTH-2: `almost_full` asserts when count >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 2: `almost_empty` asserts when count <= AE_LEVEL. Legal range 0..DEPTH-1.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous flush; has priority over wr/rd.
- wr  input  1  write request.
- datain  input  WIDTH  write data, sampled when a write is accepted.
- rd  input  1  read request.
- dataout  output  WIDTH  registered read data.
- emp  output  1  FIFO empty (count==0).
- full  output  1  FIFO full (count==DEPTH).
- almost_empty  output  1  count <= AE_LEVEL.
- almost_full  output  1  count >= AF_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: a write was rejected.
- underflow  output  1  one-cycle pulse: a read was rejected.

## Operation
- Storage: DEPTH x WIDTH array, write pointer and read pointer, each $clog2(DEPTH) bits wide. Pointers wrap naturally from DEPTH-1 to 0.
- count is a registered counter. All four status flags are decoded from the registered count, so they change on the same edge as count.
- Write acceptance: a write is accepted when wr=1 and either full=0, or full=1 with rd=1.
- Accepted write: datain is stored at the write pointer and the write pointer increments.
- Read acceptance: a read is accepted when rd=1 and emp=0.
- Accepted read: dataout <= mem[rd_ptr] and the read pointer increments.
- Count update per edge:
  - write only: +1
  - read only: -1
  - both accepted: unchanged
- Simultaneous wr and rd when empty: the write is accepted, the read is rejected, underflow pulses, and count becomes 1. The written word is not bypassed to dataout.
- Simultaneous wr and rd when full: both are accepted and count stays DEPTH. No overflow pulse.
- Rejected write (wr=1, full=1, rd=0): data is dropped, the array and pointers are unchanged, and overflow=1 for one cycle.
- Rejected read (rd=1, emp=1): dataout holds its previous value, pointers are unchanged, and underflow=1 for one cycle.
- clr=1:
  - pointers and count go to 0 and dataout goes to 0;
  - overflow and underflow are 0 that cycle;
  - wr and rd are ignored that cycle;
  - array contents are don't-care.
- rst=1 (asynchronous):
  - immediately forces pointers=0, count=0, dataout=0, overflow=0, underflow=0;
  - flags follow: emp=1, almost_empty=1, full=0, almost_full=0 (for AF_LEVEL>0);
  - a reset mid-stream discards all contents;
  - deassertion is synchronous to clk by system contract.

## Timing
- Write-to-visible: a word written at edge N can be read by rd at edge N+1, and appears on dataout after edge N+1.
- Read latency is 1 cycle: rd sampled at edge N gives dataout valid after edge N.
- Flags and count reflect all operations accepted at the most recent edge. There are no combinational input-to-output paths.
- overflow and underflow are asserted exactly for the cycle following the rejected request's edge.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset, then write 0x44, 0x55, 0x22, then read 3 -> dataout is 0x44, 0x55, 0x22 on successive cycles. count goes 1,2,3,2,1,0. emp=1 at the end.
- Write 16 words 0x00..0x0F, then write 0xAA -> full=1 and almost_full=1 from count 14; one overflow pulse; count stays 16. Read 16 -> 0x00..0x0F in order, and 0xAA is never seen.
- At full, drive wr=1 (0xBB) and rd=1 for one cycle -> dataout=0x00, count=16, no overflow. The final read of the drain returns 0xBB.
- Empty FIFO, wr=1 (0x77) and rd=1 together -> underflow pulse, count=1, dataout unchanged. The next read returns 0x77.
- Interleave 40 writes (0x00..0x27) with lagging reads so the pointers wrap twice -> read data equals write order, count never exceeds 16, no overflow or underflow.
- Load 5 words, then:
  - assert clr with wr=1 -> count=0, emp=1, dataout=0, and the write is ignored;
  - load 3 more words and assert rst asynchronously mid-cycle -> outputs reach their reset values before the next edge.
